// File: rtl/m_cp0_if.sv
// m_cp0_if: bundles the CP0 register-access, victim and interrupt signals.
// The pipeline side (master) drives requests; m_cp0 (slave) answers them.
interface m_cp0_if;
    logic        i_we;
    logic [4:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic [31:0] i_vpc;
    logic        i_bd;
    logic [4:0]  i_excCode;
    logic [5:0]  i_hwint;
    logic        i_exl_clr;
    logic        o_req;
    logic [31:0] o_epc;

    modport master (
        output i_we, i_addr, i_wdata, i_vpc, i_bd, i_excCode, i_hwint, i_exl_clr,
        input  o_rdata, o_req, o_epc
    );

    modport slave (
        input  i_we, i_addr, i_wdata, i_vpc, i_bd, i_excCode, i_hwint, i_exl_clr,
        output o_rdata, o_req, o_epc
    );
endinterface

// File: rtl/m_cp0.sv
// m_cp0: MIPS coprocessor 0 in the M stage. Holds SR(12), Cause(13) and
// EPC(14), decides exception/interrupt entry and serves mfc0/mtc0/eret.
// Optional macro CP0_TIMER_EN adds Count(9)/Compare(11) and a sticky timer
// interrupt TI that feeds IP[15] and reads back at Cause[30].
module m_cp0 (
    input logic    i_clk,
    input logic    i_reset,
    m_cp0_if.slave bus
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [5:0]  ip_next;
    logic        ti_bit;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        wr_sr;
    logic        wr_epc;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = ~req & bus.i_we & (bus.i_addr == REG_COUNT);
    assign wr_compare = ~req & bus.i_we & (bus.i_addr == REG_COMPARE);
    assign ti_bit     = ti;

    // Free-running Count, Compare register and the sticky compare-match flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            count <= wr_count ? bus.i_wdata : count + 32'd1;
            if (wr_compare) begin
                compare <= bus.i_wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign ti_bit = 1'b0;
`endif

    // mtc0 writes only land when no exception is being taken this cycle
    assign wr_sr  = ~req & bus.i_we & (bus.i_addr == REG_SR);
    assign wr_epc = ~req & bus.i_we & (bus.i_addr == REG_EPC);

    // Request decision: masked interrupts beat exceptions, EXL masks both
    always_comb begin
        ip_next    = bus.i_hwint | {ti_bit, 5'b0};
        int_req    = (|(ip_next & sr_im)) & sr_ie & ~sr_exl;
        exc_req    = (bus.i_excCode != 5'd0) & ~sr_exl;
        req        = (int_req | exc_req) & ~i_reset;
    end

    assign bus.o_req = req;
    assign bus.o_epc = epc;

    // SR: entry sets EXL; otherwise mtc0 lands first and eret then clears EXL
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sr_im  <= 6'd0;
            sr_exl <= 1'b0;
            sr_ie  <= 1'b0;
        end else if (req) begin
            sr_exl <= 1'b1;
        end else begin
            if (wr_sr) begin
                sr_im  <= bus.i_wdata[15:10];
                sr_exl <= bus.i_wdata[1] & ~bus.i_exl_clr;
                sr_ie  <= bus.i_wdata[0];
            end else if (bus.i_exl_clr) begin
                sr_exl <= 1'b0;
            end
        end
    end

    // Cause: IP samples the interrupt lines every edge; BD/ExcCode on entry
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
        end else begin
            cause_ip <= ip_next;
            if (req) begin
                cause_bd  <= bus.i_bd;
                cause_exc <= int_req ? 5'd0 : bus.i_excCode;
            end
        end
    end

    // EPC: victim PC (backed up one slot for delay slots) or mtc0 data
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            epc <= 32'd0;
        end else if (req) begin
            epc <= bus.i_bd ? bus.i_vpc - 32'd4 : bus.i_vpc;
        end else if (wr_epc) begin
            epc <= bus.i_wdata;
        end
    end

    // mfc0 read mux over the current register images
    always_comb begin
        bus.o_rdata = 32'd0;
        case (bus.i_addr)
            REG_SR:    bus.o_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            REG_CAUSE: bus.o_rdata = {cause_bd, ti_bit, 14'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            REG_EPC:   bus.o_rdata = epc;
`ifdef CP0_TIMER_EN
            REG_COUNT:   bus.o_rdata = count;
            REG_COMPARE: bus.o_rdata = compare;
`endif
            default:   bus.o_rdata = 32'd0;
        endcase
    end
endmodule

// File: doc/m_cp0.md
Name: m_cp0

Overview:
- Coprocessor-0 for the 5-stage MIPS pipeline, located in the M stage.
- Receives exception codes from upstream, including the E-stage ALU overflow flags (AriOv is encoded as Ov=12; DMOv becomes AdEL=4 or AdES=5 by the memory-access kind).
- Also receives external hardware interrupts.
- Decides exception/interrupt entry, holds SR/Cause/EPC, and serves mfc0/mtc0/eret.
- o_req flushes the pipeline and redirects the PC to the handler; o_epc supplies the eret target.

Parameters:
- HANDLER_UNUSED_N, 0, reserved. The block has no functional parameters; register numbers are fixed: SR=12, Cause=13, EPC=14.

Ports:
- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_we  input  1  mtc0 write enable
- i_addr  input  5  CP0 register number for read and write
- i_wdata  input  32  mtc0 write data
- o_rdata  output  32  mfc0 read data, combinational
- i_vpc  input  32  PC of the M-stage instruction (the victim)
- i_bd  input  1  victim is in a branch delay slot
- i_excCode  input  5  pending exception code of the victim; 0 means none
- i_hwint  input  6  external interrupt lines, level-sensitive
- i_exl_clr  input  1  eret in M stage
- o_req  output  1  take exception/interrupt this cycle, combinational
- o_epc  output  32  current EPC register value

Behaviour:
- Reset (async, i_reset=1):
  - SR, Cause and EPC are all cleared to 0.
  - o_req is forced to 0 while i_reset=1.
  - o_rdata follows i_addr from the cleared registers.
- SR (12) fields: IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause (13) fields: BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0. Cause is read-only to mtc0.
- EPC (14): full 32 bits, writable.
- Request logic:
  - int_req = |(Cause.IP_next & SR.IM) & SR.IE & ~SR.EXL, where Cause.IP_next = i_hwint.
  - exc_req = (i_excCode != 0) & ~SR.EXL.
  - o_req = int_req | exc_req.
  - An interrupt takes priority over a simultaneous exception.
- IP sampling: Cause.IP <= i_hwint on every edge, unconditionally.
- On an edge with o_req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : i_excCode.
  - Cause.BD <= i_bd.
  - EPC <= i_bd ? i_vpc-4 : i_vpc (32-bit wraparound; i_vpc=0 with BD gives 0xFFFF_FFFC).
  - Any mtc0 write in the same cycle is discarded.
  - i_exl_clr in the same cycle is ignored (entry wins).
- On an edge with o_req=0:
  - If i_exl_clr=1, SR.EXL <= 0.
  - If i_we=1, the addressed writable register is updated:
    - SR: only IM/EXL/IE bits are stored.
    - EPC: all bits are stored.
    - Cause and unimplemented numbers: no effect.
  - If i_we and i_exl_clr are both set and the write targets SR, the write lands first and EXL is then cleared.
- Reads:
  - o_rdata is the current register image; unimplemented numbers read 0.
  - There is no write-to-read bypass: mfc0 sees the value written by an mtc0 one cycle later.
- o_epc is the registered EPC; a same-cycle mtc0 EPC is not forwarded.
- Nesting: while EXL=1, all requests are masked. An exception arriving then is dropped with no state change.
- Reset asserted mid-operation clears all state immediately; no pending request is remembered.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Count (reg 9) increments by 1 every cycle, wrapping from 0xFFFF_FFFF to 0.
  - Compare (reg 11) is added.
  - Both are mtc0-writable and reset to 0. An mtc0 to Count overrides that cycle's increment.
  - When Count == Compare at an edge, sticky TI is set. TI is ORed into Cause.IP[15] (alongside i_hwint[5]) and into int_req.
  - An mtc0 to Compare clears TI.
  - TI is also readable at Cause[30].
- When undefined: regs 9 and 11 read 0, writes are ignored, Cause[30]=0, and no timer logic is synthesised.

Test Plan:
- Overflow entry: SR=0x0000_0000, i_excCode=12, i_vpc=0x0000_3010, i_bd=0 -> o_req=1 that cycle; next cycle SR=0x2, Cause=0x0000_0030, EPC=0x0000_3010, o_epc=0x0000_3010.
- Delay-slot AdEL: i_excCode=4, i_bd=1, i_vpc=0x0000_3024 -> EPC=0x0000_3020, Cause=0x8000_0010.
- Interrupt vs exception: mtc0 SR=0x0000_0401, then i_hwint=6'b000001 with i_excCode=12 in the same cycle -> o_req=1, Cause.ExcCode=0, Cause.IP=0x0400. IE=0 or IM masked -> no interrupt request.
- Masking/eret: with EXL=1, i_excCode=10 -> o_req=0, state unchanged. Assert i_exl_clr -> EXL=0 next cycle; a held i_hwint[0] with IM[10]=1, IE=1 then raises o_req.
- mtc0/priority/reset:
  - mtc0 EPC=0x1234_5678 -> o_rdata reads it at addr 14 the next cycle.
  - mtc0 Cause=0xFFFF_FFFF -> no change.
  - mtc0 concurrent with o_req -> write dropped.
  - Async i_reset mid-cycle -> SR, Cause and EPC become 0 before the next edge.
- CP0_TIMER_EN:
  - Compare=5, Count=0, IM[15]=1, IE=1 -> o_req rises in the cycle after Count reaches 5.
  - mtc0 Compare -> o_req deasserts.
  - Without the macro, regs 9 and 11 read 0.
